// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: default widths, ALU control
// codes, the payload carried across the EX/MEM boundary and skid states.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SUB = 3'd6,
    ALU_SRA = 3'd7
  } alu_ctrl_t;

  // Everything the memory/writeback stage needs from one executed instruction.
  // branch_taken and reg_write are resolved before capture, so they are stored.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  branch_taken;
    logic [ALU_DATA_W-1:0] target;
  } ex_payload_t;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_result_stage_skid.sv
// Two-entry skid buffer (main + skid). Upstream ready is a flop, so it never
// depends combinationally on out_ready. Flush empties both entries but keeps
// the data registers, so out_data holds its last value.
module skid_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_q;
  skid_state_t      state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // Next occupancy and which entry loads from where this cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Offered payload is discarded; a downstream handshake still completes.
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = SKID_FULL;
          end else if (out_xfer) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_d        = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // Occupancy register; in_ready is precomputed from the next state.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID_FULL);
    end
  end

  // Payload entries; cleared only by reset so outputs never show X.
  always_ff @(posedge clk) begin
    // NOTE: the data entries are reset too, because out_data is observable while out_valid=0.
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// EX/MEM boundary register behind the ALU. Resolves BEQ/BNE at capture and
// hands one result per transfer downstream through a two-entry skid buffer.
// Optional operand forwarding outputs are enabled by defining ALU_FWD_EN.
// DATA_W/REG_AW must match the alu_pkg payload widths.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_is_branch,
  input  logic              in_branch_ne,
  input  logic [DATA_W-1:0] in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
`ifdef ALU_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  ex_payload_t in_pl;
  ex_payload_t out_pl;

  // Branch resolution and write-enable masking on the incoming payload.
  always_comb begin
    in_pl.result       = in_result;
    in_pl.rd           = in_rd;
    in_pl.reg_write    = in_reg_write & ~in_is_branch;
    in_pl.branch_taken = in_is_branch & (in_zero ^ in_branch_ne);
    in_pl.target       = in_target;
  end

  skid_buffer #(
    .WIDTH($bits(ex_payload_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl)
  );

  assign out_result    = out_pl.result;
  assign out_rd        = out_pl.rd;
  assign out_reg_write = out_pl.reg_write;
  assign branch_taken  = out_pl.branch_taken;
  assign branch_target = out_pl.target;

`ifdef ALU_FWD_EN
  // Bypass from the main entry into the ALU operands; x0 is never forwarded.
  always_comb begin
    fwd_valid = out_valid & out_pl.reg_write & (out_pl.rd != '0);
    fwd_rd    = out_pl.rd;
    fwd_data  = out_pl.result;
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: an occupancy model plus a scoreboard
// queue of expected payloads, compared whenever out_valid is high.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_is_branch;
  logic        in_branch_ne;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        branch_taken;
  logic [31:0] branch_target;
`ifdef ALU_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;
  int cnt   = 0;
  ex_payload_t q[$];

  alu_result_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_is_branch (in_is_branch),
    .in_branch_ne (in_branch_ne),
    .in_target    (in_target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
`ifdef ALU_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic rw, input logic br, input logic ne, input logic z);
    in_valid     = v;
    in_result    = res;
    in_rd        = rd;
    in_reg_write = rw;
    in_is_branch = br;
    in_branch_ne = ne;
    in_zero      = z;
    in_target    = res ^ 32'hA5A5_0000;
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // DUT against the model, advances the model, then moves to the next falling edge.
  task automatic tick();
    ex_payload_t e;
    logic in_x;
    logic out_x;
    check("in_ready", in_ready, (cnt < 2));
    check("out_valid", out_valid, (cnt > 0));
    if (q.size() > 0) begin
      check("out_result", out_result, q[0].result);
      check("out_rd", out_rd, q[0].rd);
      check("out_reg_write", out_reg_write, q[0].reg_write);
      check("branch_taken", branch_taken, q[0].branch_taken);
      check("branch_target", branch_target, q[0].target);
    end
    out_x = (cnt > 0) && out_ready;
    in_x  = in_valid && (cnt < 2) && !flush;
    if (out_x) e = q.pop_front();
    if (flush) begin
      q.delete();
      cnt = 0;
    end else begin
      if (in_x) begin
        e.result       = in_result;
        e.rd           = in_rd;
        e.reg_write    = in_reg_write && !in_is_branch;
        e.branch_taken = in_is_branch && (in_zero != in_branch_ne);
        e.target       = in_target;
        q.push_back(e);
      end
      cnt = cnt + int'(in_x) - int'(out_x);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_out_reg_write", out_reg_write, 1'b0);
    check("rst_branch_taken", branch_taken, 1'b0);
    check("rst_branch_target", branch_target, 32'h0);

    // Single beat
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("single_out_result", out_result, 32'h5);
    check("single_out_rd", out_rd, 5'd3);
    tick();
    tick();

    // Backpressure: two accepted, third held off
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h33, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_third_out", out_result, 32'h33);
    tick();
    tick();

    // Branch resolution: BEQ taken, BNE not taken, write masked
    drive(1'b1, 32'h40, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("beq_taken", branch_taken, 1'b1);
    check("beq_no_write", out_reg_write, 1'b0);
    drive(1'b1, 32'h41, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("bne_not_taken", branch_taken, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Flush while full with a payload offered
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h51, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h44, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Streaming 1..8
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 5'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

`ifdef ALU_FWD_EN
    // Forwarding: x0 suppressed, real destination forwarded
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_x0_valid", fwd_valid, 1'b0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h78, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_valid", fwd_valid, 1'b1);
    check("fwd_rd", fwd_rd, 5'd7);
    check("fwd_data", fwd_data, 32'h78);
    out_ready = 1'b1;
    tick();
    tick();
`endif

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
